ysyx_25020047_ifu: RTL and testbench

Instruction fetch unit that sits directly upstream of the decode stage in the single-issue, non-pipelined core. It owns the architectural PC and issues one word fetch per instruction over a valid/ready request/response memory interface. It holds the fetched word until decode accepts it, then waits for the commit-time next-PC (dnpc) before fetching again. Multi-cycle memory latency and decode back-pressure are both handled by an explicit FSM.

---
 rtl/ysyx_25020047_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_25020047_ifu.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_ifu.sv
// ============================================================================
// ysyx_25020047_ifu : instruction fetch unit, one fetch per committed instr.
// Optional perf counters via YSYX_25020047_IFU_PERF_EN.    Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25020047_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_dnpc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc
`ifdef YSYX_25020047_IFU_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    EXEC = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t state;
  logic   misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  // Handshake valids depend only on registered state, never on an input.
  assign mem_req_valid = (state == REQ) && !misaligned;
  assign mem_req_addr  = pc;
  assign inst_valid    = (state == OUT);
  assign snpc          = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // A misaligned pc never reaches the bus; it is reported as a fault.
          if (misaligned) begin
            inst       <= '0;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
            state      <= OUT;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            inst       <= mem_resp_data;
            inst_pc    <= pc;
            inst_fault <= mem_resp_err;
            state      <= OUT;
          end
        end
        OUT: begin
          if (inst_ready) state <= EXEC;
        end
        EXEC: begin
          if (upd_valid) begin
            pc    <= upd_dnpc;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef YSYX_25020047_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (state == OUT && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if ((state == REQ && !mem_req_ready) || (state == WAIT && !mem_resp_valid))
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_ifu.sv
// ============================================================================
// tb_ysyx_25020047_ifu : directed bench with transaction-level fetch model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25020047_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        upd_valid;
  logic [31:0] upd_dnpc;
  logic [31:0] pc, snpc;
`ifdef YSYX_25020047_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_stall_cnt;
  logic [63:0] stall0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // memory knobs and bookkeeping
  int          ready_delay = 0, resp_delay = 0;
  bit          err_knob = 0, force_en = 0;
  logic [31:0] force_data = 0;
  logic [31:0] last_data = 0;
  logic        last_err = 0;
  int          acc_total = 0;
  int          acc0;

  ysyx_25020047_ifu dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .upd_valid(upd_valid), .upd_dnpc(upd_dnpc),
    .pc(pc), .snpc(snpc)
`ifdef YSYX_25020047_IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ready after ready_delay cycles, response resp_delay
  // cycles after acceptance. Keeps responding across a DUT reset.
  initial begin : mem_model
    bit          acc, pending;
    logic [31:0] acc_addr, pend_addr;
    int          rdy_cnt, pend_cnt;
    pending = 0; rdy_cnt = 0; pend_cnt = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    forever begin
      @(negedge clk);
      acc      = mem_req_valid && mem_req_ready && !rst;
      acc_addr = mem_req_addr;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      mem_resp_err   = 0;
      if (acc) begin
        pending = 1; pend_addr = acc_addr; pend_cnt = resp_delay; mem_req_ready = 0;
      end
      if (pending) begin
        if (pend_cnt == 0) begin
          mem_resp_valid = 1;
          mem_resp_data  = force_en ? force_data : word_of(pend_addr);
          mem_resp_err   = err_knob;
          last_data      = mem_resp_data;
          last_err       = err_knob;
          pending        = 0;
        end else pend_cnt--;
      end else if (mem_req_valid) begin
        if (!mem_req_ready) begin
          if (rdy_cnt >= ready_delay) mem_req_ready = 1;
          else rdy_cnt++;
        end
      end else rdy_cnt = 0;
    end
  end

  // Architectural model: the pc only moves on a commit that follows a
  // delivered instruction; each fetch is one bus request; outputs under
  // back-pressure hold.
  logic [31:0] exp_pc = RST_PC, exp_snpc, held_addr, h_inst, h_pc;
  logic        h_fault;
  bit          delivered = 0, hold_req = 0, hold_inst = 0;
  int          req_since = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = RST_PC; delivered = 0; hold_req = 0; hold_inst = 0; req_since = 0;
    end else begin
      exp_snpc = exp_pc + 32'd4;
      chk("pc", pc, exp_pc);
      chk("snpc", snpc, exp_snpc);
      if (hold_req) begin
        chk("req_hold_valid", mem_req_valid, 1'b1);
        chk("req_hold_addr", mem_req_addr, held_addr);
      end
      if (hold_inst) begin
        chk("inst_hold_valid", inst_valid, 1'b1);
        chk("inst_hold_word", inst, h_inst);
        chk("inst_hold_pc", inst_pc, h_pc);
        chk("inst_hold_fault", inst_fault, h_fault);
      end
      if (mem_req_valid) chk("req_addr", mem_req_addr, exp_pc);
      if (exp_pc[1:0] != 2'b00) chk("no_req_misaligned", mem_req_valid, 1'b0);
      if (inst_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        if (exp_pc[1:0] != 2'b00) begin
          chk("inst_misal", inst, 32'h0);
          chk("fault_misal", inst_fault, 1'b1);
        end else begin
          chk("inst_word", inst, last_data);
          chk("inst_fault", inst_fault, last_err);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        req_since++; acc_total++;
        chk("one_req_per_fetch", req_since, 1);
      end
      hold_req  = mem_req_valid && !mem_req_ready;
      held_addr = mem_req_addr;
      hold_inst = inst_valid && !inst_ready;
      h_inst = inst; h_pc = inst_pc; h_fault = inst_fault;
      if (delivered && upd_valid) begin
        exp_pc = upd_dnpc; delivered = 0; req_since = 0;
      end
      if (inst_valid && inst_ready) delivered = 1;
    end
  end

  task automatic wait_inst(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!inst_valid && n < 60);
    chk(name, inst_valid, 1'b1);
  endtask

  // inst_ready stays low for 1+extra cycles of OUT, then one handshake.
  task automatic accept(input int extra);
    @(posedge clk); #1;
    repeat (extra) begin @(posedge clk); #1; end
    inst_ready = 1;
    @(posedge clk); #1;
    inst_ready = 0;
  endtask

  task automatic commit(input logic [31:0] dnpc);
    upd_valid = 1; upd_dnpc = dnpc;
    @(posedge clk); #1;
    upd_valid = 0;
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin : watchdog
    #50000;
    miscompares++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    summary();
    $finish;
  end

  initial begin : main
    rst = 1; inst_ready = 0; upd_valid = 0; upd_dnpc = 0;
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", inst_fault, 1'b0);
    @(posedge clk); #1; rst = 0;

    // zero-wait fetch: IDLE, REQ, WAIT, OUT at cycles 0..3
    @(negedge clk); chk("c0_no_req", mem_req_valid, 1'b0);
    @(negedge clk); chk("c1_req", mem_req_valid, 1'b1);
    chk("c1_addr", mem_req_addr, 32'h8000_0000);
    @(negedge clk); chk("c2_no_inst", inst_valid, 1'b0);
    @(negedge clk); chk("c3_inst_valid", inst_valid, 1'b1);
    chk("c3_inst", inst, 32'h0010_0093);
    chk("c3_inst_pc", inst_pc, 32'h8000_0000);
    chk("c3_fault", inst_fault, 1'b0);
    accept(0);

    // back-pressure: ready low 3, response 4 cycles late, decode stalls 2
    ready_delay = 3; resp_delay = 4;
    acc0 = acc_total;
`ifdef YSYX_25020047_IFU_PERF_EN
    stall0 = perf_stall_cnt;
    chk("perf_fetch_1", perf_fetch_cnt, 64'd1);
`endif
    commit(32'h8000_0004);
    wait_inst("bp_inst_timeout");
    chk("bp_inst", inst, 32'h8000_0004 ^ 32'h1357_9BDF);
    chk("bp_single_req", acc_total - acc0, 1);
`ifdef YSYX_25020047_IFU_PERF_EN
    chk("perf_stall_7", perf_stall_cnt - stall0, 64'd7);
`endif
    accept(1);
    ready_delay = 0; resp_delay = 0;
`ifdef YSYX_25020047_IFU_PERF_EN
    chk("perf_fetch_2", perf_fetch_cnt, 64'd2);
`endif

    // commit redirect
    commit(32'h8000_0010);
    @(negedge clk);
    chk("cm_req", mem_req_valid, 1'b1);
    chk("cm_addr", mem_req_addr, 32'h8000_0010);
    chk("cm_snpc", snpc, 32'h8000_0014);
    wait_inst("cm_inst_timeout");
    accept(0);

    // misaligned target: fault without a bus request
    commit(32'h8000_0006);
    @(negedge clk); chk("mis_no_req", mem_req_valid, 1'b0);
    @(negedge clk); chk("mis_valid", inst_valid, 1'b1);
    chk("mis_inst", inst, 32'h0);
    chk("mis_pc", inst_pc, 32'h8000_0006);
    chk("mis_fault", inst_fault, 1'b1);
    accept(1);

    // bus error plus a spurious commit while the instruction is pending
    err_knob = 1; force_en = 1; force_data = 32'hDEAD_BEEF;
    commit(32'h8000_0020);
    wait_inst("err_inst_timeout");
    chk("err_inst", inst, 32'hDEAD_BEEF);
    chk("err_fault", inst_fault, 1'b1);
    @(posedge clk); #1; upd_valid = 1; upd_dnpc = 32'h1234_5678;
    @(posedge clk); #1; upd_valid = 0;
    @(negedge clk);
    chk("spur_pc", pc, 32'h8000_0020);
    chk("spur_still_out", inst_valid, 1'b1);
    accept(0);
    err_knob = 0; force_en = 0;

    // snpc wrap at the top of the address space
    commit(32'hFFFF_FFFC);
    @(negedge clk); chk("wrap_snpc", snpc, 32'h0);
    wait_inst("wrap_inst_timeout");
    accept(0);

    // reset while waiting; the late response lands in IDLE and is dropped
    resp_delay = 1;
    commit(32'h8000_0040);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rw_pc", pc, 32'h8000_0000);
    chk("rw_no_inst", inst_valid, 1'b0);
    @(negedge clk);
    chk("rw_req", mem_req_valid, 1'b1);
    chk("rw_addr", mem_req_addr, 32'h8000_0000);
    wait_inst("rw_inst_timeout");
    chk("rw_inst", inst, 32'h0010_0093);
    chk("rw_inst_pc", inst_pc, 32'h8000_0000);
    accept(0);
    resp_delay = 0;

    repeat (3) @(posedge clk);
    summary();
    $finish;
  end

endmodule

`default_nettype wire
